// File: rtl/mmcm_pkg.sv
// Shared types and default widths for the MMCM dynamic phase-shift stepper.
package mmcm_pkg;

  localparam int unsigned STEP_W_DEF         = 16;
  localparam int unsigned POS_W_DEF          = 20;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam int unsigned MAX_POS_DEF        = 560;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ps_state_t;

endpackage

// File: rtl/mmcm_phase_stepper.sv
// Steps the MMCM fine phase one PSEN/PSDONE handshake at a time and tracks position.
// Optional position clamp compiled in with `define MMCM_PHASE_LIMIT_EN.
module mmcm_phase_stepper
  import mmcm_pkg::*;
#(
  parameter int unsigned STEP_W         = STEP_W_DEF,
  parameter int unsigned POS_W          = POS_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned MAX_POS        = MAX_POS_DEF
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic signed [STEP_W-1:0] req_steps,
  input  logic                     abort,
  input  logic                     err_clr,
  output logic                     psen,
  output logic                     psincdec,
  input  logic                     psdone,
  output logic                     busy,
  output logic                     done,
  output logic signed [POS_W-1:0]  pos,
  output logic                     err_timeout,
  output logic                     err_limit
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ps_state_t             state, state_n;
  logic [STEP_W-1:0]     remaining, remaining_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic signed [POS_W-1:0] pos_n, pos_step;
  logic [STEP_W-1:0]     steps_mag;
  logic                  dir_req, dir_n;
  logic                  abort_q, abort_n;
  logic                  done_n, tmo_set, lim_set;
  logic                  lim_idle, lim_wait;

  // Magnitude as unsigned so the most negative request maps to 2^(STEP_W-1).
  assign steps_mag = req_steps[STEP_W-1] ? STEP_W'(-req_steps) : STEP_W'(req_steps);
  assign dir_req   = ~req_steps[STEP_W-1];
  assign pos_step  = psincdec ? pos + POS_W'(1) : pos - POS_W'(1);
  assign req_ready = (state == IDLE) & aresetn;

`ifdef MMCM_PHASE_LIMIT_EN
  localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(MAX_POS);
  localparam logic signed [POS_W-1:0] POS_MIN = -POS_MAX;

  // A step that would leave [-MAX_POS, +MAX_POS] is never issued.
  assign lim_idle = (dir_req  && (pos == POS_MAX))      || (!dir_req  && (pos == POS_MIN));
  assign lim_wait = (psincdec && (pos_step == POS_MAX)) || (!psincdec && (pos_step == POS_MIN));
`else
  assign lim_idle = 1'b0;
  assign lim_wait = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    cnt_n       = cnt;
    pos_n       = pos;
    dir_n       = psincdec;
    abort_n     = abort_q;
    done_n      = 1'b0;
    tmo_set     = 1'b0;
    lim_set     = 1'b0;
    case (state)
      IDLE: begin
        abort_n = 1'b0;
        if (req_valid) begin
          if (req_steps == '0) begin
            done_n = 1'b1;
          end else begin
            dir_n       = dir_req;
            remaining_n = steps_mag;
            if (lim_idle) begin
              lim_set     = 1'b1;
              done_n      = 1'b1;
              remaining_n = '0;
            end else begin
              state_n = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        if (abort) abort_n = 1'b1;
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (abort) abort_n = 1'b1;
        if (psdone) begin
          pos_n       = pos_step;
          remaining_n = remaining - STEP_W'(1);
          if ((remaining == STEP_W'(1)) || abort_q || abort) begin
            done_n  = 1'b1;
            abort_n = 1'b0;
            state_n = IDLE;
          end else if (lim_wait) begin
            lim_set     = 1'b1;
            done_n      = 1'b1;
            abort_n     = 1'b0;
            remaining_n = '0;
            state_n     = IDLE;
          end else begin
            state_n = ISSUE;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Missing PSDONE: give up silently, no done pulse.
          tmo_set     = 1'b1;
          remaining_n = '0;
          abort_n     = 1'b0;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered datapath and outputs; psen/busy follow the next state.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      psen        <= 1'b0;
      psincdec    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pos         <= '0;
      remaining   <= '0;
      cnt         <= '0;
      abort_q     <= 1'b0;
      err_timeout <= 1'b0;
      err_limit   <= 1'b0;
    end else begin
      psen        <= (state_n == ISSUE);
      psincdec    <= dir_n;
      busy        <= (state_n != IDLE);
      done        <= done_n;
      pos         <= pos_n;
      remaining   <= remaining_n;
      cnt         <= cnt_n;
      abort_q     <= abort_n;
      err_timeout <= tmo_set | (err_timeout & ~err_clr);
      err_limit   <= lim_set | (err_limit & ~err_clr);
    end
  end

endmodule
